// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the SAP-2-style computer: widths, opcodes,
// control states and ALU operations.
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 16;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDA  = 8'h10,
        OP_STA  = 8'h11,
        OP_LDB  = 8'h12,
        OP_ADD  = 8'h20,
        OP_SUB  = 8'h21,
        OP_AND  = 8'h22,
        OP_OR   = 8'h23,
        OP_XOR  = 8'h24,
        OP_OUTA = 8'hE0,
        OP_HLT  = 8'hFF
    } opcode_e;

    typedef enum logic [3:0] {
        ST_F0, ST_F1, ST_F2, ST_F3, ST_F4,
        ST_E0, ST_E1, ST_E2, ST_E3, ST_E4, ST_E5,
        ST_HALT
    } state_e;

    // Encoding matches the low three bits of the ALU opcodes (20..24).
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    function automatic logic is_mem_ref(logic [DATA_WIDTH-1:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_LDB) ||
               (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/gp_register.sv
// Generic loadable register with asynchronous clear; used for the A and B registers.
module gp_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] latched_data
);

    logic [WIDTH-1:0] latched_data_d;

    always_comb begin
        latched_data_d = load ? d : latched_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latched_data <= '0;
        end else begin
            latched_data <= latched_data_d;
        end
    end

endmodule

// File: rtl/ram.sv
// Single-port synchronous RAM: registered read of mem[addr] every clock, synchronous write.
module ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents survive reset, so neither the array nor the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

`ifndef SYNTHESIS
    task automatic dump();
        for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
            if (mem[i] != '0) begin
                $display("mem[%04h] = %02h", i, mem[i]);
            end
        end
    endtask
`endif

endmodule

// File: rtl/sap_computer.sv
// SAP-2-style 8-bit computer: fetch/execute control FSM, ALU, flags and output
// register around a synchronous RAM and the A/B registers.
module sap_computer
    import arch_defs_pkg::*;
#(
    parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic                  flag_zero_o,
    output logic                  flag_carry_o,
    output logic                  flag_negative_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] out_val_q, out_val_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;
    logic                  neg_q, neg_d;
    logic                  halt_q, halt_d;
    logic                  halt;

    logic                  a_load, b_load, ram_we;
    logic [DATA_WIDTH-1:0] a_in, a_val, b_val, ram_rdata;
    logic [DATA_WIDTH:0]   alu_out;

    // Returns {carry_out, result}; SUB is A + ~B + 1 so carry means "no borrow".
    function automatic logic [DATA_WIDTH:0] alu_exec(alu_op_e op,
                                                     logic [DATA_WIDTH-1:0] a,
                                                     logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] r;
        r = '0;
        case (op)
            ALU_ADD: r = {1'b0, a} + {1'b0, b};
            ALU_SUB: r = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
            ALU_AND: r = {1'b0, a & b};
            ALU_OR:  r = {1'b0, a | b};
            ALU_XOR: r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign halt    = halt_q;
    assign alu_out = alu_exec(alu_op_e'(ir_q[2:0]), a_val, b_val);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mar_d     = mar_q;
        ir_d      = ir_q;
        lo_d      = lo_q;
        out_val_d = out_val_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        halt_d    = halt_q;
        a_load    = 1'b0;
        b_load    = 1'b0;
        ram_we    = 1'b0;
        a_in      = ram_rdata;

        unique case (state_q)
            ST_F0: begin
                mar_d   = pc_q;
                state_d = ST_F1;
            end
            ST_F1: state_d = ST_F2;
            ST_F2: begin
                ir_d    = ram_rdata;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = ST_F3;
            end
            ST_F3: begin
                mar_d   = pc_q;
                state_d = ST_F4;
            end
            ST_F4: begin
                if (is_mem_ref(ir_q) || ir_q == OP_OUTA) begin
                    state_d = ST_E0;
                end else if (ir_q == OP_HLT) begin
                    halt_d  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_F0;
                end
            end
            ST_E0: begin
                if (ir_q == OP_OUTA) begin
                    out_val_d = a_val;
                    state_d   = ST_F0;
                end else begin
                    // MAR must point at the high address byte, i.e. the incremented PC.
                    lo_d    = ram_rdata;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    mar_d   = pc_q + ADDR_WIDTH'(1);
                    state_d = ST_E1;
                end
            end
            ST_E1: state_d = ST_E2;
            ST_E2: begin
                mar_d   = {ram_rdata, lo_q};
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = ST_E3;
            end
            ST_E3: state_d = ST_E4;
            ST_E4: begin
                state_d = ST_F0;
                case (ir_q)
                    OP_LDA: a_load = 1'b1;
                    OP_STA: ram_we = 1'b1;
                    OP_LDB: b_load = 1'b1;
                    default: begin
                        b_load  = 1'b1;
                        state_d = ST_E5;
                    end
                endcase
            end
            ST_E5: begin
                a_load  = 1'b1;
                a_in    = alu_out[DATA_WIDTH-1:0];
                carry_d = alu_out[DATA_WIDTH];
                zero_d  = (alu_out[DATA_WIDTH-1:0] == '0);
                neg_d   = alu_out[DATA_WIDTH-1];
                state_d = ST_F0;
            end
            ST_HALT: state_d = halt ? ST_HALT : ST_F0;
            default: state_d = ST_F0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_F0;
            pc_q      <= '0;
            mar_q     <= '0;
            ir_q      <= '0;
            lo_q      <= '0;
            out_val_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            neg_q     <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            ir_q      <= ir_d;
            lo_q      <= lo_d;
            out_val_q <= out_val_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            neg_q     <= neg_d;
            halt_q    <= halt_d;
        end
    end

    ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (mar_q),
        .wdata (a_val),
        .rdata (ram_rdata)
    );

    gp_register #(.WIDTH(DATA_WIDTH)) u_register_A (
        .clk          (clk),
        .reset        (reset),
        .load         (a_load),
        .d            (a_in),
        .latched_data (a_val)
    );

    gp_register #(.WIDTH(DATA_WIDTH)) u_register_B (
        .clk          (clk),
        .reset        (reset),
        .load         (b_load),
        .d            (ram_rdata),
        .latched_data (b_val)
    );

    assign out_val         = out_val_q;
    assign flag_zero_o     = zero_q;
    assign flag_carry_o    = carry_q;
    assign flag_negative_o = neg_q;

endmodule

// File: tb/tb_sap_computer.sv
// Self-checking bench for sap_computer: directed programs plus random programs
// compared against an instruction-level interpreter of the machine.
module tb_sap_computer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] out_val;
    logic       flag_zero_o, flag_carry_o, flag_negative_o;

    sap_computer dut (
        .clk             (clk),
        .reset           (reset),
        .out_val         (out_val),
        .flag_zero_o     (flag_zero_o),
        .flag_carry_o    (flag_carry_o),
        .flag_negative_o (flag_negative_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference machine state
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  m_a, m_b, m_out;
    logic        m_z, m_c, m_n;
    logic [15:0] m_pc;
    int          m_cycles;

    task automatic clear_all();
        for (int i = 0; i < 65536; i++) begin
            dut.u_ram.mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
    endtask

    task automatic put(input int addr, input logic [7:0] val);
        dut.u_ram.mem[addr] = val;
        ref_mem[addr] = val;
    endtask

    function automatic bit op_is_mem(input logic [7:0] op);
        return (op >= 8'h10 && op <= 8'h12) || (op >= 8'h20 && op <= 8'h24);
    endfunction

    // Interprets the program instruction by instruction, accumulating clock counts.
    task automatic run_model();
        logic [15:0] pc;
        logic [15:0] ea;
        logic [7:0]  op;
        int unsigned r;
        int          guard;
        pc = 16'h0000;
        m_a = 0; m_b = 0; m_out = 0; m_z = 0; m_c = 0; m_n = 0;
        m_cycles = 0;
        guard = 0;
        while (guard < 1000) begin
            guard++;
            op = ref_mem[pc];
            pc = pc + 16'd1;
            if (op == 8'hFF) begin
                m_cycles += 5;
                break;
            end
            if (op_is_mem(op)) begin
                ea = {ref_mem[pc + 16'd1], ref_mem[pc]};
                pc = pc + 16'd2;
                if (op == 8'h10) begin
                    m_a = ref_mem[ea];
                    m_cycles += 10;
                end else if (op == 8'h11) begin
                    ref_mem[ea] = m_a;
                    m_cycles += 10;
                end else if (op == 8'h12) begin
                    m_b = ref_mem[ea];
                    m_cycles += 10;
                end else begin
                    m_b = ref_mem[ea];
                    case (op)
                        8'h20: r = int'(m_a) + int'(m_b);
                        8'h21: r = int'(m_a) + (255 - int'(m_b)) + 1;
                        8'h22: r = int'(m_a & m_b);
                        8'h23: r = int'(m_a | m_b);
                        default: r = int'(m_a ^ m_b);
                    endcase
                    m_c = (r > 255);
                    m_a = 8'(r % 256);
                    m_z = (m_a == 0);
                    m_n = (m_a >= 128);
                    m_cycles += 11;
                end
            end else if (op == 8'hE0) begin
                m_out = m_a;
                m_cycles += 6;
            end else begin
                m_cycles += 5;
            end
        end
        m_pc = pc;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic compare_state(input string name);
        check({name, "_A"}, dut.u_register_A.latched_data, m_a);
        check({name, "_B"}, dut.u_register_B.latched_data, m_b);
        check({name, "_out"}, out_val, m_out);
        check({name, "_Z"}, flag_zero_o, m_z);
        check({name, "_C"}, flag_carry_o, m_c);
        check({name, "_N"}, flag_negative_o, m_n);
        check({name, "_pc"}, dut.pc_q, m_pc);
        for (int i = 16'h0200; i < 16'h0210; i++) begin
            check($sformatf("%s_mem%04h", name, i), dut.u_ram.mem[i], ref_mem[i]);
        end
        check({name, "_mem0100"}, dut.u_ram.mem[16'h0100], ref_mem[16'h0100]);
    endtask

    // Model, release reset, count edges to halt, compare final machine state.
    task automatic run_and_compare(input string name);
        int c;
        run_model();
        release_reset();
        c = 0;
        while (c < 3000) begin
            @(posedge clk);
            #1;
            c++;
            if (dut.halt) break;
        end
        check({name, "_halt_cycles"}, c, m_cycles);
        compare_state(name);
    endtask

    task automatic put_mref(inout int pa, input logic [7:0] op, input logic [15:0] ea);
        put(pa, op);
        put(pa + 1, ea[7:0]);
        put(pa + 2, ea[15:8]);
        pa += 3;
    endtask

    logic [7:0] rnd_ops [0:10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21,
                                    8'h22, 8'h23, 8'h24, 8'hE0, 8'h37};

    initial begin
        int pa;
        int c;
        logic [7:0] op;
        logic [15:0] snap_pc;
        logic [7:0] snap_a, snap_b, snap_out;
        logic [2:0] snap_f;

        // Directed: AND with exact update timing
        reset = 1'b1;
        clear_all();
        pa = 0;
        put(16'h0200, 8'hF0);
        put(16'h0201, 8'h0F);
        put_mref(pa, 8'h10, 16'h0200);
        put_mref(pa, 8'h22, 16'h0201);
        put(pa, 8'hFF);
        #1;
        check("rst_A", dut.u_register_A.latched_data, 8'h00);
        check("rst_out", out_val, 8'h00);
        check("rst_flags", {flag_zero_o, flag_carry_o, flag_negative_o}, 3'b000);
        check("rst_pc", dut.pc_q, 16'h0000);
        release_reset();
        repeat (9) @(posedge clk);
        #1;
        check("and_A_edge9", dut.u_register_A.latched_data, 8'h00);
        @(posedge clk);
        #1;
        check("and_A_edge10", dut.u_register_A.latched_data, 8'hF0);
        repeat (10) @(posedge clk);
        #1;
        check("and_A_edge20", dut.u_register_A.latched_data, 8'hF0);
        @(posedge clk);
        #1;
        check("and_A", dut.u_register_A.latched_data, 8'h00);
        check("and_B", dut.u_register_B.latched_data, 8'h0F);
        check("and_ZCN", {flag_zero_o, flag_carry_o, flag_negative_o}, 3'b100);
        c = 21;
        while (!dut.halt && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("and_halt_within_50", dut.halt, 1'b1);

        // Directed: ADD with carry
        reset = 1'b1;
        clear_all();
        pa = 0;
        put(16'h0200, 8'hF0);
        put(16'h0201, 8'h20);
        put_mref(pa, 8'h10, 16'h0200);
        put_mref(pa, 8'h20, 16'h0201);
        put(pa, 8'hFF);
        run_and_compare("add");
        check("add_A_const", dut.u_register_A.latched_data, 8'h10);
        check("add_ZCN_const", {flag_zero_o, flag_carry_o, flag_negative_o}, 3'b010);

        // Directed: SUB with borrow, then SUB to zero
        reset = 1'b1;
        clear_all();
        pa = 0;
        put(16'h0200, 8'h05);
        put(16'h0201, 8'h07);
        put_mref(pa, 8'h10, 16'h0200);
        put_mref(pa, 8'h21, 16'h0201);
        put(pa, 8'hFF);
        run_and_compare("sub1");
        check("sub1_A_const", dut.u_register_A.latched_data, 8'hFE);
        check("sub1_ZCN_const", {flag_zero_o, flag_carry_o, flag_negative_o}, 3'b001);

        reset = 1'b1;
        clear_all();
        pa = 0;
        put(16'h0201, 8'h07);
        put_mref(pa, 8'h10, 16'h0201);
        put_mref(pa, 8'h21, 16'h0201);
        put(pa, 8'hFF);
        run_and_compare("sub2");
        check("sub2_A_const", dut.u_register_A.latched_data, 8'h00);
        check("sub2_ZCN_const", {flag_zero_o, flag_carry_o, flag_negative_o}, 3'b110);

        // Directed: STA/LDB/OUTA; flags set by the SUB must survive the LDA
        reset = 1'b1;
        clear_all();
        pa = 0;
        put(16'h0200, 8'h5A);
        put(16'h0201, 8'h07);
        put_mref(pa, 8'h10, 16'h0201);
        put_mref(pa, 8'h21, 16'h0201);
        put_mref(pa, 8'h10, 16'h0200);
        put_mref(pa, 8'h11, 16'h0100);
        put_mref(pa, 8'h12, 16'h0100);
        put(pa, 8'hE0);
        put(pa + 1, 8'hFF);
        run_and_compare("sta");
        check("sta_mem0100_const", dut.u_ram.mem[16'h0100], 8'h5A);
        check("sta_B_const", dut.u_register_B.latched_data, 8'h5A);
        check("sta_out_const", out_val, 8'h5A);
        check("sta_ZC_kept", {flag_zero_o, flag_carry_o}, 2'b11);

        // HLT stability
        snap_pc  = dut.pc_q;
        snap_a   = dut.u_register_A.latched_data;
        snap_b   = dut.u_register_B.latched_data;
        snap_out = out_val;
        snap_f   = {flag_zero_o, flag_carry_o, flag_negative_o};
        repeat (20) @(posedge clk);
        #1;
        check("hlt_pc", dut.pc_q, m_pc);
        check("hlt_pc_held", dut.pc_q, snap_pc);
        check("hlt_A_held", dut.u_register_A.latched_data, snap_a);
        check("hlt_B_held", dut.u_register_B.latched_data, snap_b);
        check("hlt_out_held", out_val, snap_out);
        check("hlt_flags_held", {flag_zero_o, flag_carry_o, flag_negative_o}, snap_f);
        check("hlt_halt_held", dut.halt, 1'b1);

        // Reset mid-instruction, then rerun the same program from PC 0
        reset = 1'b1;
        clear_all();
        pa = 0;
        put(16'h0200, 8'h5A);
        put(16'h0201, 8'h33);
        put_mref(pa, 8'h10, 16'h0200);
        put(pa, 8'hE0);
        pa++;
        put_mref(pa, 8'h12, 16'h0201);
        put_mref(pa, 8'h20, 16'h0201);
        put(pa, 8'hFF);
        release_reset();
        repeat (23) @(posedge clk);
        #1;
        check("mid_A_before", dut.u_register_A.latched_data, 8'h5A);
        check("mid_out_before", out_val, 8'h5A);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_A", dut.u_register_A.latched_data, 8'h00);
        check("mid_rst_B", dut.u_register_B.latched_data, 8'h00);
        check("mid_rst_out", out_val, 8'h00);
        check("mid_rst_flags", {flag_zero_o, flag_carry_o, flag_negative_o}, 3'b000);
        check("mid_rst_pc", dut.pc_q, 16'h0000);
        check("mid_rst_halt", dut.halt, 1'b0);
        check("mid_rst_ram", dut.u_ram.mem[16'h0200], 8'h5A);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_pc_edge2", dut.pc_q, 16'h0000);
        @(posedge clk);
        #1;
        check("mid_pc_edge3", dut.pc_q, 16'h0001);
        run_and_compare("mid_rerun");

        // Randomized programs
        for (int t = 0; t < 10; t++) begin
            int n;
            reset = 1'b1;
            clear_all();
            for (int i = 0; i < 16; i++) begin
                put(16'h0200 + i, 8'($urandom_range(0, 255)));
            end
            pa = 0;
            n = $urandom_range(4, 14);
            // Start with an LDA so A carries interesting data
            put_mref(pa, 8'h10, 16'h0200 + 16'($urandom_range(0, 15)));
            for (int k = 0; k < n; k++) begin
                op = rnd_ops[$urandom_range(0, 10)];
                if (op_is_mem(op)) begin
                    put_mref(pa, op, 16'h0200 + 16'($urandom_range(0, 15)));
                end else begin
                    put(pa, op);
                    pa++;
                end
            end
            put(pa, 8'hFF);
            run_and_compare($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sap_computer.md
Name: sap_computer

Overview:
- Top-level of the 8-bit SAP-2-style computer. It contains the program counter, MAR, IR, A and B registers, ALU, flags register, output register, a synchronous RAM and a microcoded control FSM.
- Program and data are preloaded into RAM before reset is released.
- Executes one instruction at a time with a fixed T-state count per opcode, and stops on HLT.

Parameters:
- DATA_WIDTH, 8, datapath and memory word width (from shared arch package)
- ADDR_WIDTH, 16, RAM address width; RAM depth = 2**ADDR_WIDTH

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- out_val  output  DATA_WIDTH  output register, loaded by OUTA
- flag_zero_o  output  1  Z flag register
- flag_carry_o  output  1  C flag register
- flag_negative_o  output  1  N flag register

Behaviour:
- Required hierarchy, used by benches:
  - RAM instance u_ram with array mem[0:2**ADDR_WIDTH-1] and task dump() (prints nonzero words).
  - Register instances u_register_A and u_register_B, each holding its value in latched_data.
  - Top-level signal halt.
- Reset: PC, MAR, IR, A, B, operand latches, out_val, Z/C/N and halt all clear to 0; FSM goes to F0. RAM contents are untouched. Reset mid-instruction aborts it with no partial register writes.
- RAM: synchronous read, data valid one clock after MAR loads; synchronous write.
- Instruction format: 1-byte opcode. Memory-reference opcodes are followed by a 16-bit address, little-endian (lo, hi).
- Fetch, 5 states:
  - F0: MAR<=PC.
  - F1: RAM wait.
  - F2: IR<=RAM; PC++.
  - F3: MAR<=PC.
  - F4: decode/RAM wait.
- Memory-reference execute prefix:
  - E0: lo<=RAM; PC++; MAR<=PC.
  - E1: wait.
  - E2: MAR<={RAM,lo}; PC++.
  - E3: wait.
- Opcodes and remaining states:
  - 00 NOP: back to F0 after F4.
  - 10 LDA addr: E4 A<=RAM. A updates on the 10th rising edge of the instruction. Flags unchanged.
  - 11 STA addr: E4 RAM[MAR]<=A.
  - 12 LDB addr: E4 B<=RAM.
  - 20 ADD / 21 SUB / 22 AND / 23 OR / 24 XOR addr: E4 B<=RAM; E5 A<=A op B and flags update. A updates on the 11th edge of the instruction.
  - E0 OUTA: after F4, out_val<=A (6 clocks total).
  - FF HLT: halt<=1; FSM parks; no further PC/register/flag change until reset.
  - Undefined opcode: executes as NOP.
- ALU and flags, updated only by ALU ops:
  - Z = (result==0); N = result[7].
  - ADD: C = carry-out.
  - SUB: A+~B+1, C = carry-out (1 = no borrow).
  - AND/OR/XOR: C<=0.
  - Results wrap mod 256.
- PC wraps from FFFF to 0000.
- Outputs are registered; flag outputs mirror the flags register.

Decomposition:
- Shared package arch_defs_pkg holds DATA_WIDTH, ADDR_WIDTH, the opcode enum, the FSM state enum and the ALU op enum.
- One sub-module is natural: ram, instance u_ram.
- Generic register sub-module instantiated as u_register_A/u_register_B.
- Control FSM and ALU live in the top.

Test Plan:
- Reset: assert reset mid-run → A=00, B=00, out_val=00, Z=C=N=0, PC restarts at 0000.
- AND flags: program LDA [F0]; AND [0F]; HLT:
  - 10 edges after reset release: A=F0.
  - 11 edges later: A=00, B=0F, Z=1, C=0, N=0.
  - halt asserts within 50 clocks.
- ADD carry: LDA [F0]; ADD [20]; HLT → A=10, C=1, Z=0, N=0.
- SUB: LDA [05]; SUB [07] → A=FE, N=1, C=0, Z=0. LDA [07]; SUB [07] → A=00, Z=1, C=1.
- STA/OUTA: LDA [5A]; STA 0100; LDB 0100; OUTA; HLT → mem[0100]=5A, B=5A, out_val=5A. LDA leaves flags unchanged.
- HLT stability: after halt, hold 20 clocks → PC, A, B, flags and out_val constant.
